// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Covers the op codes, the ALU default value, the sequencer FSM states and the buffered command record.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    localparam logic [7:0] ALU_DEFAULT    = 8'hAC;
    localparam logic [7:0] DIVZERO_RESULT = 8'hFF;

    // Default tag width of a buffered command; the top-level TAG_W is expected to match it
    localparam int CMD_TAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } seq_state_t;

    typedef struct packed {
        logic [7:0]           a;
        logic [7:0]           b;
        logic [3:0]           op;
        logic [CMD_TAG_W-1:0] tag;
    } cmd_t;

    function automatic logic is_divzero(input cmd_t c);
        return (c.op == OP_DIV) && (c.b == 8'd0);
    endfunction

endpackage

// File: rtl/alu_seq_cmd_fifo.sv
// Command FIFO for the ALU sequencer. The head entry is read combinationally and writes are synchronous.
// The pointers carry an extra wrap bit so that full and empty can be told apart.
module alu_seq_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t head,
    output logic full,
    output logic empty
);

    localparam int IDX_W = $clog2(CMD_DEPTH);

    logic [IDX_W:0] wr_ptr;
    logic [IDX_W:0] rd_ptr;
    cmd_t           mem [CMD_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (IDX_W+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (IDX_W+1)'(1);
        end
    end

    // Storage is not reset: an entry is only read after the pointers say it was written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[IDX_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a registered ALU. It buffers commands, issues them, captures results and returns tagged responses.
// Optional macro ALU_SEQ_DIVZERO_CHECK_EN answers DIV-by-zero commands directly, without using the ALU.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int TAG_W     = CMD_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    cmd_t             cmd_in;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop_p0;
    logic             divzero_p0;
    logic             capture_p2;
    logic [TAG_W-1:0] tag_p1;

    always_comb begin
        cmd_in     = '0;
        cmd_in.a   = cmd_a;
        cmd_in.b   = cmd_b;
        cmd_in.op  = cmd_op;
        cmd_in.tag = CMD_TAG_W'(cmd_tag);
    end

    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;

    alu_seq_cmd_fifo #(
        .CMD_DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop_p0),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    assign divzero_p0 = is_divzero(head);
`else
    assign divzero_p0 = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // A pop happens from IDLE, or from RESP on handshake; a divide-by-zero pop jumps straight to RESP
    always_comb begin
        state_nxt  = state;
        pop_p0     = 1'b0;
        capture_p2 = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_p0    = 1'b1;
                    state_nxt = divzero_p0 ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                capture_p2 = 1'b1;
                state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop_p0    = 1'b1;
                        state_nxt = divzero_p0 ? ST_RESP : ST_ISSUE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- issue stage (p1): operands to the ALU; capture stage (p2): result into response regs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            tag_p1     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_tag    <= '0;
        end else begin
            if (pop_p0) begin
                alu_a   <= head.a;
                alu_b   <= head.b;
                alu_sel <= head.op;
                tag_p1  <= TAG_W'(head.tag);
            end
            if (capture_p2) begin
                rsp_result <= alu_out;
                rsp_carry  <= alu_carry;
                rsp_tag    <= tag_p1;
            end else if (pop_p0 && divzero_p0) begin
                rsp_result <= DIVZERO_RESULT;
                rsp_carry  <= 1'b0;
                rsp_tag    <= TAG_W'(head.tag);
            end
        end
    end

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                     rsp_err <= 1'b0;
        else if (capture_p2)           rsp_err <= 1'b0;
        else if (pop_p0 && divzero_p0) rsp_err <= 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer, driving a registered ALU stub.
// A queue-based reference predicts each response, and a negedge monitor pops and compares every handshake.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [3:0]       cmd_op = '0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [7:0]       alu_a, alu_b;
    logic [3:0]       alu_sel;
    logic [7:0]       alu_out = '0;
    logic             alu_carry = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic             rsp_carry;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    alu_cmd_sequencer #(.CMD_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behaviour of the external ALU; its divide-by-zero value is arbitrary
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 8'd0) ? 8'h00 : a / b;
            default: return 8'hAC;
        endcase
    endfunction

    function automatic logic carry_fn(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8];
    endfunction

    always @(posedge clk) begin
        alu_out   <= alu_fn(alu_a, alu_b, alu_sel);
        alu_carry <= carry_fn(alu_a, alu_b);
    end

    typedef struct {
        logic [7:0]       res;
        logic             carry;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb[$];
    exp_t got[$];
    int   hs_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   acc_cyc = 0;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] op, input logic [TAG_W-1:0] tag);
        exp_t m;
        m.res   = alu_fn(a, b, op);
        m.carry = carry_fn(a, b);
        m.tag   = tag;
        m.err   = 1'b0;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        if (op == 4'd3 && b == 8'd0) begin
            m.res   = 8'hFF;
            m.carry = 1'b0;
            m.err   = 1'b1;
        end
`endif
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: compare each handshake with the scoreboard head, and check that the response holds while stalled
    logic             stall_q = 1'b0;
    logic [7:0]       prev_res;
    logic             prev_carry;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_err;
    exp_t             mon_e;
    exp_t             mon_g;

    always @(negedge clk) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", rsp_valid, 1);
                check("hold_result", rsp_result, prev_res);
                check("hold_carry", rsp_carry, prev_carry);
                check("hold_tag", rsp_tag, prev_tag);
                check("hold_err", rsp_err, prev_err);
            end
            if (rsp_valid && rsp_ready) begin
                mon_g.res = rsp_result; mon_g.carry = rsp_carry;
                mon_g.tag = rsp_tag;    mon_g.err = rsp_err;
                got.push_back(mon_g);
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got tag %0h with nothing outstanding", rsp_tag);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_result", rsp_result, mon_e.res);
                    check("rsp_carry", rsp_carry, mon_e.carry);
                    check("rsp_tag", rsp_tag, mon_e.tag);
                    check("rsp_err", rsp_err, mon_e.err);
                end
            end
            stall_q    = rsp_valid && !rsp_ready;
            prev_res   = rsp_result;
            prev_carry = rsp_carry;
            prev_tag   = rsp_tag;
            prev_err   = rsp_err;
        end
    end

    // rsp_ready driver: a fixed level, or random once rand_rdy is set
    bit   rand_rdy = 1'b0;
    logic rdy_fixed = 1'b0;
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_fixed;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [TAG_W-1:0] tag);
        int waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        while (!cmd_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: cmd_ready=0 after %0d cycles, required 1", waited);
        end else begin
            sb.push_back(model(a, b, op, tag));
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        rdy_fixed = 1'b1;
        repeat (2) @(negedge clk);

        // Single ADD with 4-cycle latency
        got.delete(); hs_cyc.delete();
        send(8'hF0, 8'h20, 4'd0, 4'd3);
        drain(50);
        check("add_count", got.size(), 1);
        if (got.size() == 1) begin
            check("add_latency", hs_cyc[0] - acc_cyc, 4);
            check("add_result", got[0].res, 8'h10);
            check("add_carry", got[0].carry, 1);
            check("add_tag", got[0].tag, 3);
        end

        // Back-to-back SUB, MUL, DIV with one response every 3 cycles
        got.delete(); hs_cyc.delete();
        send(8'h05, 8'h03, 4'd1, 4'd1);
        send(8'h10, 8'h11, 4'd2, 4'd2);
        send(8'h64, 8'h07, 4'd3, 4'd4);
        drain(60);
        check("b2b_count", got.size(), 3);
        if (got.size() == 3) begin
            check("b2b_sub", got[0].res, 8'h02);
            check("b2b_mul", got[1].res, 8'h10);
            check("b2b_div", got[2].res, 8'h0E);
            check("b2b_gap1", hs_cyc[1] - hs_cyc[0], 3);
            check("b2b_gap2", hs_cyc[2] - hs_cyc[1], 3);
        end

        // Backpressure: five commands fill the FSM and the FIFO
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        got.delete();
        for (int i = 0; i < 5; i++)
            send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 3)), 4'(i + 8));
        repeat (4) @(negedge clk);
        check("full_cmd_ready", cmd_ready, 0);
        check("full_busy", busy, 1);
        check("bp_rsp_valid", rsp_valid, 1);
        rdy_fixed = 1'b1;
        drain(100);
        check("bp_count", got.size(), 5);

        // Undefined op
        got.delete();
        send(8'h01, 8'h01, 4'b1010, 4'd7);
        drain(50);
        check("undef_count", got.size(), 1);
        if (got.size() == 1) begin
            check("undef_result", got[0].res, 8'hAC);
            check("undef_carry", got[0].carry, 0);
        end

        // Divide by zero
        got.delete(); hs_cyc.delete();
        send(8'h09, 8'h00, 4'd3, 4'd5);
        drain(50);
        check("div0_count", got.size(), 1);
        if (got.size() == 1) begin
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
            check("div0_latency", hs_cyc[0] - acc_cyc, 2);
            check("div0_result", got[0].res, 8'hFF);
            check("div0_err", got[0].err, 1);
`else
            check("div0_latency", hs_cyc[0] - acc_cyc, 4);
            check("div0_err", got[0].err, 0);
`endif
        end

        // Reset while in CAPTURE with two commands queued
        send(8'h11, 8'h22, 4'd0, 4'd1);
        send(8'h33, 8'h44, 4'd1, 4'd2);
        send(8'h55, 8'h66, 4'd2, 4'd3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        sb.delete();
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_result", rsp_result, 0);
        check("mid_rst_rsp_carry", rsp_carry, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        got.delete();
        send(8'h80, 8'h81, 4'd0, 4'd9);
        drain(50);
        check("post_rst_count", got.size(), 1);
        if (got.size() == 1) check("post_rst_result", got[0].res, 8'h01);

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [3:0] op;
            logic [7:0] b;
            op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            send(8'($urandom), b, op, 4'(i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rand_rdy = 1'b0;
        rdy_fixed = 1'b1;
        drain(2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
